spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Downstream consumer of the SPI byte receiver. Takes its 8-bit byte output plus "byte changed" flag, and the SPI chip-select, from the SPI clock domain into the system clock domain.
- Parses each chip-select frame as a command byte followed by a data byte.
- Issues single-cycle register write strobes or read requests to the register file.

Parameters:
- SYNC_STAGES, 2, number of flops in each CDC synchronizer chain (legal values 2..4).
- ADDR_W, 7, register address width. Equal to the command byte width minus the R/W bit. Fixed at 7 for the current frame format.

Ports:
- CLK  input  1  system clock (single clock domain for all state).
- RST  input  1  asynchronous, active-high reset.
- SPI_CS  input  1  raw SPI chip-select from pad, active-low, asynchronous to CLK.
- SPI_BUFFER  input  8  completed byte from SPI receiver (SPI domain). Reads 8'hFF while CS is high.
- SPI_CHANGED  input  1  SPI-domain flag, high for several SPI clocks after each completed byte.
- WR_EN  output  1  one-cycle register write strobe.
- WR_ADDR  output  ADDR_W  write address, valid with WR_EN.
- WR_DATA  output  8  write data, valid with WR_EN.
- RD_EN  output  1  one-cycle read request strobe.
- RD_ADDR  output  ADDR_W  read address, valid with RD_EN.
- FRAME_ERR  output  1  one-cycle pulse on a malformed or aborted frame.

Behaviour:
- Reset (async assert, sync deassert handled externally): all synchronizer flops = 1 for CS and 0 for CHANGED; state = IDLE; all outputs 0.
- CDC:
  - SPI_CS and SPI_CHANGED each pass through a SYNC_STAGES chain.
  - A rising edge of synced CHANGED generates byte_stb, registered one cycle after the last sync stage.
  - SPI_BUFFER is captured into byte_q on the same edge that raises byte_stb.
  - SPI_BUFFER is multi-bit but quasi-static: it is stable for 8 SPI clocks after CHANGED rises, so no per-bit sync is used.
- Clock requirement: CLK frequency ≥ 4× SPI clock.
- Command byte format:
  - bit7: 1 = write, 0 = read.
  - bits6:0: address.
- FSM states: IDLE, CMD, DATA, DONE.
- IDLE: synced CS low → CMD.
- CMD, on byte_stb:
  - bit7 = 0 (read): RD_EN = 1 and RD_ADDR = byte_q[6:0] on the next cycle, then → DONE.
  - bit7 = 1 (write): latch addr, → DATA.
- DATA, on byte_stb: WR_EN = 1 with latched addr and WR_DATA = byte_q on the next cycle, then → DONE.
- DONE: further byte_stb in the same frame are ignored, with no error.
- Synced CS high, from any state: → IDLE on the next cycle.
  - If the state was DATA (write incomplete), FRAME_ERR pulses 1 cycle.
  - CS high in CMD with no bytes received is not an error.
- Simultaneous CS-high and byte_stb in the same cycle: CS wins. The byte is dropped, and the DATA-state error rule still applies.
- Latency: from the SPI_CHANGED rising edge to the WR_EN/RD_EN pulse is SYNC_STAGES + 2 CLK cycles.
- WR_EN and RD_EN are never high in the same cycle. Each is at most one pulse per frame.
- Outputs WR_ADDR, WR_DATA and RD_ADDR hold their last value between strobes.

Optional Feature:
- Macro: SPI_CMD_CHECKSUM_EN.
- Defined:
  - Write frames gain a third byte, CHK, equal to cmd ^ data.
  - FSM adds state CHK between DATA and DONE. WR_EN fires only after CHK arrives and matches.
  - On a mismatch, FRAME_ERR pulses instead of WR_EN.
  - CS high while in CHK also pulses FRAME_ERR.
  - Read frames are unchanged.
- Undefined: two-byte write frames as above; the CHK state is not present.

Decomposition:
- Package spi_cmd_pkg holds:
  - the state enum;
  - CMD_WRITE_BIT = 7;
  - ADDR_W default;
  - the checksum function.
- One sub-module, spi_cdc_sync: single-bit N-stage synchronizer with a reset value parameter. It is instantiated for CS and CHANGED.

Test Plan:
- Write frame: CS low, bytes 8'h85, 8'h3C, CS high → a single WR_EN with WR_ADDR = 7'h05, WR_DATA = 8'h3C, SYNC_STAGES + 2 cycles after the second CHANGED edge; FRAME_ERR = 0.
- Read frame: CS low, byte 8'h12, CS high → a single RD_EN with RD_ADDR = 7'h12; WR_EN stays 0.
- Aborted write: CS low, byte 8'hFF, CS high before the data byte → FRAME_ERR pulses once; no WR_EN.
- Extra bytes: CS low, bytes 8'h81, 8'hAA, 8'h55, 8'h77 → one WR_EN (addr 7'h01, data 8'hAA); the trailing bytes are ignored.
- Reset mid-frame: assert RST after the command byte 8'h90 → outputs 0 immediately. The following data byte in the same CS frame produces no WR_EN until CS toggles high then low.
- SPI_CMD_CHECKSUM_EN defined:
  - bytes 8'h85, 8'h3C, 8'hB9 → WR_EN.
  - CHK byte 8'hB8 → FRAME_ERR and no WR_EN.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: FSM state encoding,
// command byte layout and the write-frame checksum.
// SPI_CMD_CHECKSUM_EN adds the CHK state for three-byte write frames.
package spi_cmd_pkg;

  // Bit of the command byte that selects write (1) or read (0).
  localparam int CMD_WRITE_BIT = 7;

  // Register address width carried in the low bits of the command byte.
  localparam int ADDR_W_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
`ifdef SPI_CMD_CHECKSUM_EN
    ST_CHK  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_t;

  // Expected third byte of a checksummed write frame.
  function automatic logic [7:0] calc_chk(input logic [7:0] cmd,
                                          input logic [7:0] data);
    return cmd ^ data;
  endfunction

endpackage

// File: rtl/spi_cdc_sync.sv
// Single-bit N-stage synchronizer into the CLK domain. RST_VAL sets the
// value every flop takes on reset so the output starts in the line's
// idle level.
module spi_cdc_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], D};
    end
  end

  assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: brings chip-select and the byte-changed flag into
// the CLK domain, parses each CS frame as command byte + data byte and
// issues register write strobes / read requests.
// SPI_CMD_CHECKSUM_EN: write frames carry a third byte (cmd ^ data) that
// must match before WR_EN fires.
//
// Strobe semantics: WR_EN and RD_EN are valid-only, single-cycle strobes.
// There is no ready; the register file must accept every strobe in the
// cycle it is high. Address/data outputs are valid with their strobe and
// hold their value afterwards.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SPI_CS,
  input  logic [7:0]        SPI_BUFFER,
  input  logic              SPI_CHANGED,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              FRAME_ERR,
  output logic [2:0]        DBG_STATE
);

  logic cs_s;
  logic chg_s;
  logic chg_d;
  logic byte_stb;
  logic [7:0] byte_q;

  state_t state, state_n;
  logic              wr_en_n, rd_en_n, err_n;
  logic [ADDR_W-1:0] wr_addr_n, rd_addr_n;
  logic [7:0]        wr_data_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0] cmd_q, cmd_n;
  logic [7:0] data_q, data_n;
`endif

  // CS idles high, so its chain resets to 1; CHANGED idles low.
  spi_cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (SPI_CS),
    .Q   (cs_s)
  );

  spi_cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_chg_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (SPI_CHANGED),
    .Q   (chg_s)
  );

  // Rising edge of synced CHANGED gives byte_stb; the quasi-static SPI
  // buffer is sampled on that same edge, long before it can change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chg_d    <= 1'b0;
      byte_stb <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      chg_d    <= chg_s;
      byte_stb <= chg_s & ~chg_d;
      if (chg_s & ~chg_d) begin
        byte_q <= SPI_BUFFER;
      end
    end
  end

  // State register plus registered strobes and held address/data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      WR_EN     <= 1'b0;
      RD_EN     <= 1'b0;
      FRAME_ERR <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= 8'h00;
      RD_ADDR   <= '0;
      addr_q    <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      cmd_q     <= 8'h00;
      data_q    <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      WR_EN     <= wr_en_n;
      RD_EN     <= rd_en_n;
      FRAME_ERR <= err_n;
      WR_ADDR   <= wr_addr_n;
      WR_DATA   <= wr_data_n;
      RD_ADDR   <= rd_addr_n;
      addr_q    <= addr_n;
`ifdef SPI_CMD_CHECKSUM_EN
      cmd_q     <= cmd_n;
      data_q    <= data_n;
`endif
    end
  end

  // Frame parser: CS high always wins and returns to IDLE, flagging an
  // error only when a write was left unfinished.
  always_comb begin
    state_n   = state;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    err_n     = 1'b0;
    wr_addr_n = WR_ADDR;
    wr_data_n = WR_DATA;
    rd_addr_n = RD_ADDR;
    addr_n    = addr_q;
`ifdef SPI_CMD_CHECKSUM_EN
    cmd_n     = cmd_q;
    data_n    = data_q;
`endif
    if (cs_s) begin
      state_n = ST_IDLE;
      if (state == ST_DATA) begin
        err_n = 1'b1;
      end
`ifdef SPI_CMD_CHECKSUM_EN
      if (state == ST_CHK) begin
        err_n = 1'b1;
      end
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_CMD;
        end
        ST_CMD: begin
          if (byte_stb) begin
            if (!byte_q[CMD_WRITE_BIT]) begin
              rd_en_n   = 1'b1;
              rd_addr_n = byte_q[ADDR_W-1:0];
              state_n   = ST_DONE;
            end else begin
              addr_n  = byte_q[ADDR_W-1:0];
`ifdef SPI_CMD_CHECKSUM_EN
              cmd_n   = byte_q;
`endif
              state_n = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_stb) begin
`ifdef SPI_CMD_CHECKSUM_EN
            data_n    = byte_q;
            state_n   = ST_CHK;
`else
            wr_en_n   = 1'b1;
            wr_addr_n = addr_q;
            wr_data_n = byte_q;
            state_n   = ST_DONE;
`endif
          end
        end
`ifdef SPI_CMD_CHECKSUM_EN
        ST_CHK: begin
          if (byte_stb) begin
            if (byte_q == calc_chk(cmd_q, data_q)) begin
              wr_en_n   = 1'b1;
              wr_addr_n = addr_q;
              wr_data_n = data_q;
            end else begin
              err_n = 1'b1;
            end
            state_n = ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign DBG_STATE = state;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder. Frames are modelled at the
// byte-list level: each frame's expected strobes and their cycle stamps
// are derived from the command rules and the fixed pipeline latency.
module tb_spi_cmd_decoder;

  localparam int N    = 2;
  localparam int LAT  = N + 2;
  localparam int EV_W = 33;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SPI_CS = 1'b1;
  logic [7:0] SPI_BUFFER = 8'hFF;
  logic       SPI_CHANGED = 1'b0;
  logic       WR_EN, RD_EN, FRAME_ERR;
  logic [6:0] WR_ADDR, RD_ADDR;
  logic [7:0] WR_DATA;
  logic [2:0] DBG_STATE;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int excl_viol = 0;

  logic [7:0]      frm_q[$];
  int              stamp_q[$];
  logic [EV_W-1:0] exp_q[$];
  logic [EV_W-1:0] obs_q[$];

  spi_cmd_decoder #(.SYNC_STAGES(N), .ADDR_W(7)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .SPI_CS      (SPI_CS),
    .SPI_BUFFER  (SPI_BUFFER),
    .SPI_CHANGED (SPI_CHANGED),
    .WR_EN       (WR_EN),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .RD_EN       (RD_EN),
    .RD_ADDR     (RD_ADDR),
    .FRAME_ERR   (FRAME_ERR),
    .DBG_STATE   (DBG_STATE)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event encoding: type (1 wr, 2 rd, 3 err), addr, data, cycle stamp
  function automatic logic [EV_W-1:0] mk_ev(input logic [1:0] t, input logic [6:0] a,
                                            input logic [7:0] d, input int c);
    logic [31:0] cv;
    cv = c;
    return {t, a, d, cv[15:0]};
  endfunction

  // Monitor: sample outputs on the falling edge
  always @(negedge CLK) begin
    if (!RST) begin
      if (WR_EN && RD_EN) excl_viol = excl_viol + 1;
      if (WR_EN)     obs_q.push_back(mk_ev(2'd1, WR_ADDR, WR_DATA, cyc));
      if (RD_EN)     obs_q.push_back(mk_ev(2'd2, RD_ADDR, 8'h00, cyc));
      if (FRAME_ERR) obs_q.push_back(mk_ev(2'd3, 7'h00, 8'h00, cyc));
    end
  end

  // Driver: one SPI byte with its CHANGED pulse
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    SPI_BUFFER  = b;
    SPI_CHANGED = 1'b1;
    stamp_q.push_back(cyc);
    repeat (6) @(negedge CLK);
    SPI_CHANGED = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  // Reference model: outcome of one whole frame from its byte list
  task automatic model_frame(input int cs_cyc);
    int n;
    logic [7:0] b0;
    n = frm_q.size();
    if (n == 0) return;
    b0 = frm_q[0];
    if (b0[7] == 1'b0) exp_q.push_back(mk_ev(2'd2, b0[6:0], 8'h00, stamp_q[0] + LAT));
`ifdef SPI_CMD_CHECKSUM_EN
    else if (n >= 3) begin
      if (frm_q[2] == (b0 ^ frm_q[1])) exp_q.push_back(mk_ev(2'd1, b0[6:0], frm_q[1], stamp_q[2] + LAT));
      else exp_q.push_back(mk_ev(2'd3, 7'h00, 8'h00, stamp_q[2] + LAT));
    end
`else
    else if (n >= 2) exp_q.push_back(mk_ev(2'd1, b0[6:0], frm_q[1], stamp_q[1] + LAT));
`endif
    else exp_q.push_back(mk_ev(2'd3, 7'h00, 8'h00, cs_cyc + N + 1));
  endtask

  // Driver: whole CS frame from frm_q, expectations built alongside
  task automatic run_frame();
    int cs_cyc;
    obs_q.delete(); exp_q.delete(); stamp_q.delete();
    @(negedge CLK);
    SPI_CS = 1'b0;
    repeat (6) @(negedge CLK);
    foreach (frm_q[i]) send_byte(frm_q[i]);
    repeat (4) @(negedge CLK);
    SPI_CS = 1'b1;
    SPI_BUFFER = 8'hFF;
    cs_cyc = cyc;
    model_frame(cs_cyc);
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({WR_EN, RD_EN, FRAME_ERR} !== 3'b000) begin
      n_errors++; $display("FAIL reset_strobes got %b want 000", {WR_EN, RD_EN, FRAME_ERR});
    end
    n_checks++;
    if ({WR_ADDR, WR_DATA, RD_ADDR} !== 22'h0) begin
      n_errors++; $display("FAIL reset_regs got %h want 0", {WR_ADDR, WR_DATA, RD_ADDR});
    end
    n_checks++;
    if (DBG_STATE !== 3'd0) begin
      n_errors++; $display("FAIL reset_state got %0d want 0", DBG_STATE);
    end
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_write();
    frm_q = '{8'h85, 8'h3C};
`ifdef SPI_CMD_CHECKSUM_EN
    frm_q.push_back(8'hB9);
`endif
    run_frame();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL write_event got %h want %h", obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({WR_ADDR, WR_DATA} !== {7'h05, 8'h3C}) begin
      n_errors++; $display("FAIL write_outputs got %h/%h want 05/3c", WR_ADDR, WR_DATA);
    end
  endtask

  task automatic test_read();
    frm_q = '{8'h12};
    run_frame();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL read_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL read_event got %h want %h", obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({RD_ADDR, WR_ADDR, WR_DATA} !== {7'h12, 7'h05, 8'h3C}) begin
      n_errors++; $display("FAIL read_hold got %h/%h/%h want 12/05/3c", RD_ADDR, WR_ADDR, WR_DATA);
    end
  endtask

  task automatic test_abort();
    frm_q = '{8'hFF};
    run_frame();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL abort_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL abort_event got %h want %h", obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_extra_bytes();
`ifdef SPI_CMD_CHECKSUM_EN
    frm_q = '{8'h81, 8'hAA, 8'h2B, 8'h55, 8'h77};
`else
    frm_q = '{8'h81, 8'hAA, 8'h55, 8'h77};
`endif
    run_frame();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL extra_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL extra_event got %h want %h", obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({WR_ADDR, WR_DATA} !== {7'h01, 8'hAA}) begin
      n_errors++; $display("FAIL extra_outputs got %h/%h want 01/aa", WR_ADDR, WR_DATA);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wr_seen;
    obs_q.delete();
    @(negedge CLK);
    SPI_CS = 1'b0;
    repeat (6) @(negedge CLK);
    send_byte(8'h90);
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({WR_EN, RD_EN, FRAME_ERR, WR_ADDR, WR_DATA, RD_ADDR} !== 25'h0) begin
      n_errors++; $display("FAIL midreset_outputs got %h want 0", {WR_EN, RD_EN, FRAME_ERR, WR_ADDR, WR_DATA, RD_ADDR});
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    send_byte(8'h3C);
    repeat (4) @(negedge CLK);
    SPI_CS = 1'b1;
    SPI_BUFFER = 8'hFF;
    repeat (10) @(negedge CLK);
    wr_seen = 0;
    foreach (obs_q[i]) if (obs_q[i][EV_W-1 -: 2] == 2'd1) wr_seen++;
    n_checks++;
    if (wr_seen != 0) begin
      n_errors++; $display("FAIL midreset_no_write got %0d writes want 0", wr_seen);
    end
    // A fresh frame after CS toggled must decode normally again
    frm_q = '{8'h85, 8'h3C};
`ifdef SPI_CMD_CHECKSUM_EN
    frm_q.push_back(8'hB9);
`endif
    run_frame();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL recover_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL recover_event got %h want %h", obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    logic [7:0] b;
    for (int f = 0; f < 24; f++) begin
      frm_q.delete();
      len = $urandom_range(0, 4);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        frm_q.push_back(b);
      end
`ifdef SPI_CMD_CHECKSUM_EN
      if (len >= 3) begin
        b = frm_q[0];
        if (b[7] && ($urandom_range(0, 1) == 1)) frm_q[2] = frm_q[0] ^ frm_q[1];
      end
`endif
      run_frame();
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_errors++; $display("FAIL random_count frame %0d got %0d want %0d", f, obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL random_event frame %0d got %h want %h", f, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

`ifdef SPI_CMD_CHECKSUM_EN
  task automatic test_checksum();
    frm_q = '{8'h85, 8'h3C, 8'hB9};
    run_frame();
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== mk_ev(2'd1, 7'h05, 8'h3C, stamp_q[2] + LAT)) begin
      n_errors++; $display("FAIL chk_good got %0d events want one write", obs_q.size());
    end
    frm_q = '{8'h85, 8'h3C, 8'hB8};
    run_frame();
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0] !== mk_ev(2'd3, 7'h00, 8'h00, stamp_q[2] + LAT)) begin
      n_errors++; $display("FAIL chk_bad got %0d events want one frame error", obs_q.size());
    end
  endtask
`endif

  task automatic test_exclusive();
    n_checks++;
    if (excl_viol != 0) begin
      n_errors++; $display("FAIL strobe_exclusive got %0d overlaps want 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_extra_bytes();
    test_reset_mid_frame();
    test_random();
`ifdef SPI_CMD_CHECKSUM_EN
    test_checksum();
`endif
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
